clkgen_multi: RTL and testbench

Parametrised multi-channel clock/tick generator driven from the 50 MHz board clock. Each channel divides CLK50M by a runtime-programmable half-period count. Each channel produces a 50%-duty divided clock and a single-cycle TICK strobe per period. It serves as a shared timebase source for display scan, debounce and slow-logic clocks, with independent per-channel enable and reload.

---
 rtl/clkgen_multi.sv | 84 ++++++++
 tb/tb_clkgen_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_multi.sv
// rtl/clkgen_multi.sv - multi-channel programmable clock/tick divider
// Optional SYNC input for all-channel phase alignment under `CLKGEN_SYNC_EN.
module clkgen_multi #(
    parameter int          NCH         = 4,
    parameter int          CW          = 16,
    parameter int unsigned DEFAULT_DIV = 24999
) (
    input  logic              CLK50M,
    input  logic              RSTN,
    input  logic [NCH-1:0]    EN,
    input  logic [NCH-1:0]    LOAD,
    input  logic [CW-1:0]     DIV_IN,
`ifdef CLKGEN_SYNC_EN
    input  logic              SYNC,
`endif
    output logic [NCH-1:0]    CLKOUT,
    output logic [NCH-1:0]    TICK,
    output logic [NCH*CW-1:0] DIV_RB
);

    logic [CW-1:0]  div_q [NCH];
    logic [CW-1:0]  div_d [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] clk_q, clk_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic           sync_w;

`ifdef CLKGEN_SYNC_EN
    assign sync_w = SYNC;
`else
    assign sync_w = 1'b0;
`endif

    // LOAD outranks everything so a reload can never emit a stale toggle or tick.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            div_d[i]  = div_q[i];
            cnt_d[i]  = cnt_q[i];
            clk_d[i]  = clk_q[i];
            tick_d[i] = 1'b0;
            if (LOAD[i]) begin
                div_d[i] = DIV_IN;
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (sync_w || !EN[i]) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (cnt_q[i] == div_q[i]) begin
                cnt_d[i]  = '0;
                clk_d[i]  = ~clk_q[i];
                tick_d[i] = ~clk_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK50M or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= CW'(DEFAULT_DIV);
                cnt_q[i] <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign CLKOUT = clk_q;
    assign TICK   = tick_q;

    for (genvar g = 0; g < NCH; g++) begin : g_rb
        assign DIV_RB[g*CW +: CW] = div_q[g];
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb/tb_clkgen_multi.sv - scoreboard bench for clkgen_multi
module tb_clkgen_multi;

    logic        CLK50M = 1'b0;
    logic        RSTN;
    logic [3:0]  EN;
    logic [3:0]  LOAD;
    logic [15:0] DIV_IN;
`ifdef CLKGEN_SYNC_EN
    logic        SYNC;
`endif
    logic [3:0]  CLKOUT;
    logic [3:0]  TICK;
    logic [63:0] DIV_RB;

    int cyc = 0;
    int nvec = 0;
    int nfail = 0;

    typedef struct {
        int          at;
        int          ch;
        bit          is_rb;
        logic        clk;
        logic        tick;
        logic [15:0] rb;
    } exp_t;

    exp_t q[$];

    clkgen_multi dut (
        .CLK50M (CLK50M),
        .RSTN   (RSTN),
        .EN     (EN),
        .LOAD   (LOAD),
        .DIV_IN (DIV_IN),
`ifdef CLKGEN_SYNC_EN
        .SYNC   (SYNC),
`endif
        .CLKOUT (CLKOUT),
        .TICK   (TICK),
        .DIV_RB (DIV_RB)
    );

    always #10 CLK50M = ~CLK50M;
    always @(posedge CLK50M) cyc <= cyc + 1;

    task automatic exp_ct(input int at, input int ch, input logic c, input logic t);
        exp_t e;
        e.at = at; e.ch = ch; e.is_rb = 1'b0; e.clk = c; e.tick = t; e.rb = '0;
        q.push_back(e);
    endtask

    task automatic exp_rb(input int at, input int ch, input logic [15:0] v);
        exp_t e;
        e.at = at; e.ch = ch; e.is_rb = 1'b1; e.clk = 1'b0; e.tick = 1'b0; e.rb = v;
        q.push_back(e);
    endtask

    task automatic goto(input int k);
        while (cyc != k) begin
            @(posedge CLK50M);
            #1;
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge CLK50M) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
                nvec++;
                if (q[i].is_rb) begin
                    if (DIV_RB[q[i].ch*16 +: 16] !== q[i].rb) begin
                        nfail++;
                        $display("FAIL div_rb ch%0d cyc %0d: got %0d want %0d",
                                 q[i].ch, cyc, DIV_RB[q[i].ch*16 +: 16], q[i].rb);
                    end
                end else if (CLKOUT[q[i].ch] !== q[i].clk || TICK[q[i].ch] !== q[i].tick) begin
                    nfail++;
                    $display("FAIL clk_tick ch%0d cyc %0d: got clk=%b tick=%b want clk=%b tick=%b",
                             q[i].ch, cyc, CLKOUT[q[i].ch], TICK[q[i].ch], q[i].clk, q[i].tick);
                end
                q.delete(i);
            end else if (q[i].at < cyc) begin
                nvec++;
                nfail++;
                $display("FAIL missed_check ch%0d at %0d: got unchecked want checked", q[i].ch, q[i].at);
                q.delete(i);
            end
        end
    end

    initial begin
        #(120000 * 20);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0; EN = '0; LOAD = '0; DIV_IN = '0;
`ifdef CLKGEN_SYNC_EN
        SYNC = 1'b0;
`endif
        for (int c = 0; c < 4; c++) begin
            exp_ct(1, c, 1'b0, 1'b0);
            exp_rb(1, c, 16'd24999);
        end
        // Channel 0 at default divide, enabled together with reset release.
        goto(2);
        RSTN = 1'b1; EN = 4'b0001;
        exp_ct(25001, 0, 1'b0, 1'b0);
        exp_ct(25002, 0, 1'b1, 1'b1);
        exp_ct(25003, 0, 1'b1, 1'b0);
        exp_ct(50001, 0, 1'b1, 1'b0);
        exp_ct(50002, 0, 1'b0, 1'b0);

        // Channel 1: DIV 3, then reload to 5 on its terminal count, then EN drop.
        goto(3);
        LOAD = 4'b0010; DIV_IN = 16'd3;
        goto(4);
        LOAD = '0; EN[1] = 1'b1;
        exp_rb(4, 1, 16'd3);
        exp_ct(7, 1, 1'b0, 1'b0);
        exp_ct(8, 1, 1'b1, 1'b1);
        exp_ct(9, 1, 1'b1, 1'b0);
        exp_ct(11, 1, 1'b1, 1'b0);
        exp_ct(12, 1, 1'b0, 1'b0);
        exp_ct(15, 1, 1'b0, 1'b0);
        exp_ct(16, 1, 1'b1, 1'b1);
        exp_ct(17, 1, 1'b1, 1'b0);
        exp_ct(19, 1, 1'b1, 1'b0);
        exp_ct(20, 1, 1'b0, 1'b0);
        exp_ct(23, 1, 1'b0, 1'b0);
        exp_ct(24, 1, 1'b0, 1'b0);
        exp_rb(24, 1, 16'd5);
        exp_ct(29, 1, 1'b0, 1'b0);
        exp_ct(30, 1, 1'b1, 1'b1);
        exp_ct(31, 1, 1'b1, 1'b0);
        exp_ct(32, 1, 1'b1, 1'b0);
        exp_ct(33, 1, 1'b0, 1'b0);
        exp_ct(45, 1, 1'b0, 1'b0);
        exp_ct(46, 1, 1'b1, 1'b1);
        exp_ct(47, 1, 1'b1, 1'b0);
        goto(23);
        LOAD = 4'b0010; DIV_IN = 16'd5;
        goto(24);
        LOAD = '0;
        goto(32);
        EN[1] = 1'b0;
        goto(40);
        EN[1] = 1'b1;

        // Channel 2: DIV 0 toggles every cycle.
        goto(50);
        LOAD = 4'b0100; DIV_IN = 16'd0;
        exp_rb(51, 2, 16'd0);
        exp_ct(51, 2, 1'b0, 1'b0);
        exp_ct(52, 2, 1'b1, 1'b1);
        exp_ct(53, 2, 1'b0, 1'b0);
        exp_ct(54, 2, 1'b1, 1'b1);
        exp_ct(55, 2, 1'b0, 1'b0);
        goto(51);
        LOAD = '0; EN[2] = 1'b1;

        // Asynchronous reset mid-operation.
        goto(50010);
        RSTN = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_ct(50010, c, 1'b0, 1'b0);
            exp_rb(50010, c, 16'd24999);
            exp_ct(50013, c, 1'b0, 1'b0);
        end
        goto(50012);
        RSTN = 1'b1;

        // LOAD with EN low, then enable.
        goto(50020);
        LOAD = 4'b1000; DIV_IN = 16'd7;
        exp_rb(50021, 3, 16'd7);
        exp_ct(50028, 3, 1'b0, 1'b0);
        exp_ct(50029, 3, 1'b1, 1'b1);
        goto(50021);
        LOAD = '0; EN[3] = 1'b1;

        // Two channels loaded with the same value in one cycle.
        goto(50030);
        LOAD = 4'b0110; DIV_IN = 16'd2;
        exp_rb(50031, 1, 16'd2);
        exp_rb(50031, 2, 16'd2);
        exp_ct(50033, 1, 1'b0, 1'b0);
        exp_ct(50033, 2, 1'b0, 1'b0);
        exp_ct(50034, 1, 1'b1, 1'b1);
        exp_ct(50034, 2, 1'b1, 1'b1);
        goto(50031);
        LOAD = '0;

`ifdef CLKGEN_SYNC_EN
        goto(50040);
        LOAD = 4'b0001; DIV_IN = 16'd1;
        goto(50041);
        LOAD = 4'b0010; DIV_IN = 16'd2;
        goto(50042);
        LOAD = 4'b0100; DIV_IN = 16'd3;
        goto(50043);
        LOAD = '0;
        for (int c = 0; c < 3; c++) begin
            exp_ct(50061, c, 1'b0, 1'b0);
            exp_ct(50062, c, 1'b0, 1'b0);
        end
        exp_ct(50063, 0, 1'b1, 1'b1);
        exp_ct(50064, 0, 1'b1, 1'b0);
        exp_ct(50065, 0, 1'b0, 1'b0);
        exp_ct(50063, 1, 1'b0, 1'b0);
        exp_ct(50064, 1, 1'b1, 1'b1);
        exp_ct(50064, 2, 1'b0, 1'b0);
        exp_ct(50065, 2, 1'b1, 1'b1);
        goto(50060);
        SYNC = 1'b1;
        goto(50061);
        SYNC = 1'b0;
`endif

        goto(50080);
        @(negedge CLK50M);
        #1;
        while (q.size() > 0) begin
            nvec++;
            nfail++;
            $display("FAIL unchecked ch%0d at %0d: got pending want checked", q[0].ch, q[0].at);
            void'(q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
